serial_adder_ctrl: RTL and testbench

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/fa_bit_cell.sv | 13 +
 rtl/serial_adder_ctrl.sv | 99 +++++++++
 tb/tb_serial_adder_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int SERIAL_ADDER_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/fa_bit_cell.sv
// Single-bit full adder; purely combinational, zero latency, no flow control.
module fa_bit_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial a+b+cin, LSB first, one bit per cycle; done pulses WIDTH+1 cycles after accept.
// No backpressure: start is simply ignored while an addition is in flight or completing.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SERIAL_ADDER_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] res_reg;
  logic [WIDTH-1:0] res_next;
  logic             carry;
  logic             fa_s;
  logic             fa_co;

  fa_bit_cell u_fa (
    .x  (a_reg[count]),
    .y  (b_reg[count]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // Result with the current bit already inserted, so the final edge can load sum directly.
  always_comb begin
    res_next        = res_reg;
    res_next[count] = fa_s;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      count   <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      res_reg <= '0;
      carry   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg   <= a;
            b_reg   <= b;
            carry   <= cin;
            res_reg <= '0;
            count   <= '0;
            state   <= SHIFT;
            busy    <= 1'b1;
          end
        end
        SHIFT: begin
          res_reg <= res_next;
          carry   <= fa_co;
          if (count == LAST) begin
            // Counter holds on the last bit rather than wrapping.
            sum   <= res_next;
            cout  <= fa_co;
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            count <= count + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench: WIDTH=8 instance for timing/result/reset cases, WIDTH=1 instance exhaustive.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  logic       start1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       cin1;
  logic       busy1;
  logic       done1;
  logic [0:0] sum1;
  logic       cout1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept at edge 0; check cycles 1..10 against hand-computed result and previous outputs.
  task automatic run8(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                      input logic tc, input logic [7:0] es, input logic ec,
                      input logic [7:0] ps, input logic pc);
    a = ta; b = tb_; cin = tc; start = 1'b1;
    tick();
    start = 1'b0;
    a = ~ta; b = ~tb_; cin = ~tc;
    for (int c = 1; c <= 8; c++) begin
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_nodone"}, 32'(done), 32'd0);
      chk({tag, "_sum_hold"}, 32'(sum), 32'(ps));
      chk({tag, "_cout_hold"}, 32'(cout), 32'(pc));
      tick();
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy_lo"}, 32'(busy), 32'd0);
    chk({tag, "_sum"}, 32'(sum), 32'(es));
    chk({tag, "_cout"}, 32'(cout), 32'(ec));
    tick();
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int ndone;
    logic [2:0] vv;
    logic [1:0] e1;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    tick(); tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_busy_w1", 32'(busy1), 32'd0);
    rst_n = 1'b1;
    tick();

    run8("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    run8("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0);
    run8("a5_5a_c", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 8'h00, 1'b1);
    run8("3c_12", 8'h3C, 8'h12, 1'b0, 8'h4E, 1'b0, 8'h00, 1'b1);

    // start re-pulsed mid-run with new operands must be ignored
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    for (int c = 1; c <= 13; c++) begin
      if (c == 3) begin start = 1'b1; a = 8'h01; b = 8'h01; end
      if (c == 4) start = 1'b0;
      if (done) ndone++;
      if (c < 9) chk("repulse_sum_hold", 32'(sum), 32'h4E);
      if (c == 9) chk("repulse_done_c9", 32'(done), 32'd1);
      if (c > 9) chk("repulse_no_2nd_op", 32'(busy), 32'd0);
      if (c < 13) tick();
    end
    chk("repulse_sum", 32'(sum), 32'h30);
    chk("repulse_one_done", 32'(ndone), 32'd1);

    run8("ff_02", 8'hFF, 8'h02, 1'b0, 8'h01, 1'b1, 8'h30, 1'b0);

    // reset asserted in cycle 4 aborts the run
    a = 8'h3C; b = 8'h12; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (done) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);

    // start held high: done in cycles 9 and 19
    a = 8'h3C; b = 8'h12; cin = 1'b0; start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      chk("held_done", 32'(done), (c == 9 || c == 19) ? 32'd1 : 32'd0);
      chk("held_busy", 32'(busy), ((c >= 1 && c <= 8) || (c >= 11 && c <= 18)) ? 32'd1 : 32'd0);
    end
    start = 1'b0;
    chk("held_sum", 32'(sum), 32'h4E);
    tick(); tick();

    // start coincident with reset is dropped
    rst_n = 1'b0; start = 1'b1;
    tick();
    rst_n = 1'b1; start = 1'b0;
    chk("rst_start_busy0", 32'(busy), 32'd0);
    tick();
    chk("rst_start_busy1", 32'(busy), 32'd0);
    chk("rst_start_done", 32'(done), 32'd0);

    // WIDTH=1 exhaustive
    for (int v = 0; v < 8; v++) begin
      vv = 3'(v);
      e1 = 2'(vv[2]) + 2'(vv[1]) + 2'(vv[0]);
      a1 = vv[2]; b1 = vv[1]; cin1 = vv[0]; start1 = 1'b1;
      tick();
      start1 = 1'b0;
      chk("w1_busy", 32'(busy1), 32'd1);
      chk("w1_nodone", 32'(done1), 32'd0);
      tick();
      chk("w1_busy_lo", 32'(busy1), 32'd0);
      chk("w1_done", 32'(done1), 32'd1);
      chk("w1_result", 32'({cout1, sum1}), 32'(e1));
      tick();
      chk("w1_done_pulse", 32'(done1), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
